// File: rtl/add_pipe_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit (add_pipe).
package add_pipe_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // A legal split gives every stage the same non-zero number of bits.
  function automatic bit stages_fit(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/add_pipe_slice.sv
// One pipeline stage of add_pipe: resolves SW result bits at offset IDX*SW and
// forwards operands, lower result bits and carry; keeps a running zero flag with ADD_PIPE_FLAGS_EN.
module add_pipe_slice
  import add_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SW    = 4,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  input  logic             dn_ready,
  output logic             dn_valid,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] res_in,
  input  logic             c_in,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [WIDTH-1:0] res_q,
  output logic             c_q
`ifdef ADD_PIPE_FLAGS_EN
  ,
  input  logic             z_in,
  output logic             z_q
`endif
);

  logic             load;
  logic [SW:0]      slice_sum;
  logic [WIDTH-1:0] res_next;

  // The stage refills whenever it is empty or its contents move on this cycle.
  assign load      = !dn_valid || dn_ready;
  assign slice_sum = {1'b0, a_in[IDX*SW +: SW]} + {1'b0, b_in[IDX*SW +: SW]} + {{SW{1'b0}}, c_in};

  always_comb begin
    res_next                = res_in;
    res_next[IDX*SW +: SW]  = slice_sum[SW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      c_q      <= 1'b0;
`ifdef ADD_PIPE_FLAGS_EN
      z_q      <= 1'b0;
`endif
    end else if (load) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        a_q   <= a_in;
        b_q   <= b_in;
        res_q <= res_next;
        c_q   <= slice_sum[SW];
`ifdef ADD_PIPE_FLAGS_EN
        z_q   <= z_in && (slice_sum[SW-1:0] == '0);
`endif
      end
    end
  end

endmodule

// File: rtl/add_pipe.sv
// Pipelined two's-complement add/subtract with valid/ready back-pressure.
// Define ADD_PIPE_FLAGS_EN to add the {N,Z,C,V} flags port.
module add_pipe
  import add_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADD_PIPE_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam int SW = WIDTH / STAGES;

  if (!stages_fit(WIDTH, STAGES)) begin : g_bad_cfg
    $error("add_pipe: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] can_load;
  logic [WIDTH-1:0]  a_pipe   [STAGES+1];
  logic [WIDTH-1:0]  b_pipe   [STAGES+1];
  logic [WIDTH-1:0]  res_pipe [STAGES+1];
  logic [STAGES:0]   c_pipe;
`ifdef ADD_PIPE_FLAGS_EN
  logic [STAGES:0]   z_pipe;
  alu_flags_t        flag_bits;
`endif
  logic              unused_bits;

  assign a_pipe[0]   = a;
  assign b_pipe[0]   = sub ? ~b : b;
  assign res_pipe[0] = '0;
  assign c_pipe[0]   = cin;
`ifdef ADD_PIPE_FLAGS_EN
  assign z_pipe[0]   = 1'b1;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic up_valid;
    logic dn_ready;

    // Stage k can load unless it and every stage after it are full and stalled.
    assign can_load[k] = out_ready || !(&stage_valid[STAGES-1:k]);

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
    end else begin : g_body
      assign up_valid = stage_valid[k-1];
    end

    if (k == STAGES - 1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_inner
      assign dn_ready = can_load[k+1];
    end

    add_pipe_slice #(
      .WIDTH (WIDTH),
      .SW    (SW),
      .IDX   (k)
    ) u_slice (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (up_valid),
      .dn_ready (dn_ready),
      .dn_valid (stage_valid[k]),
      .a_in     (a_pipe[k]),
      .b_in     (b_pipe[k]),
      .res_in   (res_pipe[k]),
      .c_in     (c_pipe[k]),
      .a_q      (a_pipe[k+1]),
      .b_q      (b_pipe[k+1]),
      .res_q    (res_pipe[k+1]),
      .c_q      (c_pipe[k+1])
`ifdef ADD_PIPE_FLAGS_EN
      ,
      .z_in     (z_pipe[k]),
      .z_q      (z_pipe[k+1])
`endif
    );
  end

  assign in_ready    = can_load[0];
  assign out_valid   = stage_valid[STAGES-1];
  assign sum         = res_pipe[STAGES];
  assign cout        = c_pipe[STAGES];
  assign unused_bits = ^{a_pipe[STAGES], b_pipe[STAGES]};

`ifdef ADD_PIPE_FLAGS_EN
  // Overflow uses the operand MSBs that travelled down alongside the result.
  always_comb begin
    flag_bits.n = sum[WIDTH-1];
    flag_bits.z = z_pipe[STAGES];
    flag_bits.c = cout;
    flag_bits.v = (a_pipe[STAGES][WIDTH-1] == b_pipe[STAGES][WIDTH-1]) &&
                  (sum[WIDTH-1] != a_pipe[STAGES][WIDTH-1]);
  end

  assign flags = flag_bits;
`endif

endmodule

// File: doc/add_pipe.md
# add_pipe

Parametrised, pipelined two's-complement add/subtract unit that generalises the team's fixed 16-bit combinational adder. The WIDTH-bit carry chain is split across STAGES register stages, so wide datapaths close timing at the cost of latency. The unit sits between the ALU operand mux and the writeback path, and accepts one operation per cycle under a valid/ready handshake with full back-pressure.

## Interface
Parameters:
- WIDTH, 16, operand and result width; must be a multiple of STAGES.
- STAGES, 4, pipeline depth; each stage resolves WIDTH/STAGES bits (the slice width SW); 1 ≤ STAGES ≤ WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation presented on a, b, sub, cin.
- in_ready  output  1  unit accepts the operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  1 = subtract (B is inverted).
- cin  input  1  carry-in; set to 1 for a plain subtract.
- out_valid  output  1  result presented.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of the MSB.
- flags  output  4  {N,Z,C,V}; present only with ADD_PIPE_FLAGS_EN.

## Operation
- Effective operand b_eff = sub ? ~b : b. The result is {cout,sum} = a + b_eff + cin, computed modulo 2^(WIDTH+1).
- Stage k (0-based) adds bits [k*SW +: SW] of a and b_eff, using the registered carry from stage k-1 (cin for stage 0).
  - Stage k registers that partial sum slice and its carry.
  - Stage k also carries the still-unresolved upper operand bits forward unchanged.
  - Lower result slices are delayed alongside the operation.
- Each stage holds its own valid bit. A stage loads when it is empty or when its contents advance in the same cycle, so bubbles collapse.
- in_ready = stage-0 can load. The ready chain is combinational from out_ready back to in_ready.
- Operation order is preserved, and no operation is dropped or duplicated.
- An input is accepted on in_valid && in_ready. An output is consumed on out_valid && out_ready.
- While out_valid && !out_ready, the values on sum, cout and flags are held stable.
- STAGES=1: the unit is a single registered adder. Latency is 1, and throughput is 1 per cycle when out_ready=1.

## Timing
- Reset (asynchronous assert; deassert synchronised externally):
  - All stage valids clear.
  - out_valid=0, sum=0, cout=0, flags=0.
  - in_ready=1 after reset.
- Reset mid-operation discards every in-flight operation. No partial result appears after reset deasserts.
- Latency: an input accepted at edge n appears with out_valid=1 after edge n+STAGES-1, i.e. STAGES cycles when there are no stalls.
- Throughput: 1 operation per cycle while out_ready=1.
- Full pipeline with out_ready=0: in_ready=0 in the same cycle.
- Pipeline full and out_ready=1: a simultaneous accept and consume is allowed, and in_ready=1.
- Empty pipeline: out_valid=0. The sum output holds its last value and is don't-care to consumers.
- Overflow/wrap: results wrap modulo 2^WIDTH. cout and V report the wrap and do not saturate.

## Configuration
- ADD_PIPE_FLAGS_EN defined:
  - The flags port exists.
  - N = sum[WIDTH-1].
  - Z = (sum == 0). Z is accumulated per slice down the pipe, with no WIDTH-wide compare at the output.
  - C = cout.
  - V = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
  - The operand MSBs are carried to the final stage to compute V.
- ADD_PIPE_FLAGS_EN undefined: the flags port and all flag logic are absent. Latency and handshake are unchanged.

## Structure
- add_pipe_pkg:
  - typedef alu_flags_t, a packed struct {n,z,c,v}.
  - Flag index localparams.
  - Function checking WIDTH % STAGES == 0, used in an elaboration-time assertion.
- Sub-module add_pipe_slice:
  - One stage: SW-bit adder, slice and carry registers, valid bit, and load/advance logic.
  - add_pipe instantiates STAGES copies in a generate loop and routes the forwarded operand bits.

## Test plan
- WIDTH=16, STAGES=4, out_ready=1, single op a=0x0001, b=0x0000, sub=0, cin=0 → 4 cycles later out_valid=1, sum=0x0001, cout=0, flags={0,0,0,0}.
- Carry ripple across all slices: a=0xFFFF, b=0x0001, sub=0, cin=0 → sum=0x0000, cout=1, flags={0,1,1,0}.
- Subtract with signed overflow: a=0x8000, b=0x0001, sub=1, cin=1 → sum=0x7FFF, cout=1, flags={0,0,1,1}.
- Back-pressure: stream 6 ops back-to-back, hold out_ready=0 for 5 cycles.
  - in_ready drops once the 4 stages fill.
  - Results emerge in order, with sum held stable while stalled.
  - No loss or duplication.
- Reset mid-stream: assert rst_n=0 with 3 ops in flight → out_valid=0 immediately. After release, no stale result appears and the next op returns the correct sum.
- STAGES=1 and STAGES=16, random a/b/sub/cin with random out_ready → every result matches the reference model a + (sub?~b:b) + cin, with latency equal to STAGES.
